// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types for the CPU address-mode sequencer. Holds the
//                addressing-mode encodings, the mode enum and the sequencer
//                state enum. Imported by cpu and addr_mode_seq.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Addressing-mode encodings as presented on the mode input
    localparam logic [2:0] MODE_IMM  = 3'd0;
    localparam logic [2:0] MODE_ZP   = 3'd1;
    localparam logic [2:0] MODE_ZPX  = 3'd2;
    localparam logic [2:0] MODE_ABS  = 3'd3;
    localparam logic [2:0] MODE_ABSX = 3'd4;
    localparam logic [2:0] MODE_ABSY = 3'd5;
    localparam logic [2:0] MODE_INDX = 3'd6;
    localparam logic [2:0] MODE_INDY = 3'd7;

    typedef enum logic [2:0] {
        M_IMM  = MODE_IMM,
        M_ZP   = MODE_ZP,
        M_ZPX  = MODE_ZPX,
        M_ABS  = MODE_ABS,
        M_ABSX = MODE_ABSX,
        M_ABSY = MODE_ABSY,
        M_INDX = MODE_INDX,
        M_INDY = MODE_INDY
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPLO  = 3'd1,
        S_OPHI  = 3'd2,
        S_ZPIDX = 3'd3,
        S_PTRLO = 3'd4,
        S_PTRHI = 3'd5,
        S_FIX   = 3'd6,
        S_DONE  = 3'd7
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ea_add8.sv
`default_nettype none
// ============================================================================
//  Module      : ea_add8
//  Description : 8-bit unsigned adder with carry-out, used by the address
//                sequencer for index addition and pointer increment.
//  Ports       : a, b  - 8-bit addends
//                sum   - (a + b) mod 256
//                cout  - carry out of bit 7
//  Revision    : 1.0  initial release
// ============================================================================
module ea_add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/addr_mode_seq.sv
`default_nettype none
// ============================================================================
//  Module      : addr_mode_seq
//  Description : 6502-style addressing-mode sequencer. Fetches operand bytes,
//                performs zero-page / pointer / indexed address arithmetic
//                and delivers the effective address with a one-cycle done.
//  Parameters  : ADDR_W  - address width (9..16), high byte is ADDR_W-8 bits
//                ZP_BASE - upper address bits for zero-page/pointer accesses
//  Ports       : clk, reset_n (async, active-low), ready (low = freeze)
//                start, mode, is_store, x_in, y_in - sampled on start
//                pc_in  - address of the next operand byte
//                d_in   - read data for the current addr
//                addr   - registered bus address
//                pc_inc - operand byte consumed this cycle
//                busy, done, ea, page_cross
//  Config      : PAGE_PENALTY_EN - when defined, the FIX cycle is only taken
//                on an index carry or a store; otherwise it is always taken
//                for ABSX/ABSY/INDY.
//  Revision    : 1.0  initial release
// ============================================================================
module addr_mode_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int ZP_BASE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ready,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              is_store,
    input  logic [7:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [7:0]        d_in,
    output logic [ADDR_W-1:0] addr,
    output logic              pc_inc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ea,
    output logic              page_cross
);

    localparam int              HI_W  = ADDR_W - 8;
    localparam logic [HI_W-1:0] ZP_HI = HI_W'(ZP_BASE);

`ifdef PAGE_PENALTY_EN
    localparam logic ALWAYS_FIX = 1'b0;
`else
    localparam logic ALWAYS_FIX = 1'b1;
`endif

    state_e            state, state_nx;
    mode_e             mode_in, mode_q;
    logic              store_q;
    logic [7:0]        idx_q;      // X or Y, chosen by mode at start
    logic [7:0]        lo_q;       // operand/pointer low byte, later index sum
    logic [7:0]        ptr_q;      // zero-page pointer address
    logic [HI_W-1:0]   hi_q;
    logic [HI_W-1:0]   d_hi;
    logic [7:0]        add_a, add_b, add_sum;
    logic              add_cout;
    logic              indexed, take_fix;
    logic [ADDR_W-1:0] addr_nx, ea_nx;

    assign mode_in = mode_e'(mode);
    assign d_hi    = d_in[HI_W-1:0];
    assign indexed = (mode_q == M_ABSX) || (mode_q == M_ABSY) || (mode_q == M_INDY);
    assign take_fix = ALWAYS_FIX | add_cout | store_q;

    // One shared adder: pointer increment in PTRLO, index add everywhere else
    assign add_a = (state == S_PTRLO) ? ptr_q : lo_q;
    assign add_b = (state == S_PTRLO) ? 8'd1  : idx_q;

    ea_add8 u_add (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx = state;
        if (ready) begin
            case (state)
                S_IDLE:  if (start) state_nx = (mode_in == M_IMM) ? S_DONE : S_OPLO;
                S_OPLO: begin
                    case (mode_q)
                        M_ZP:          state_nx = S_DONE;
                        M_ZPX, M_INDX: state_nx = S_ZPIDX;
                        M_INDY:        state_nx = S_PTRLO;
                        default:       state_nx = S_OPHI;
                    endcase
                end
                S_OPHI, S_PTRHI: state_nx = (indexed && take_fix) ? S_FIX : S_DONE;
                S_ZPIDX: state_nx = (mode_q == M_INDX) ? S_PTRLO : S_DONE;
                S_PTRLO: state_nx = S_PTRHI;
                S_FIX:   state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        pc_inc = 1'b0;
        done   = 1'b0;
        busy   = (state != S_IDLE);
        if (ready) begin
            case (state)
                S_IDLE:         pc_inc = start && (mode_in == M_IMM);
                S_OPLO, S_OPHI: pc_inc = 1'b1;
                S_DONE:         done   = 1'b1;
                default:        ;
            endcase
        end
    end

    // ---------------- next bus / effective address ----------------
    // addr is registered, so each state computes the address the *next*
    // state will present. The caller's PC advances on the same edge as a
    // pc_inc cycle, hence pc_in + 1 when moving from OPLO to OPHI.
    always_comb begin
        addr_nx = addr;
        ea_nx   = ea;
        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nx = pc_in;
                    if (mode_in == M_IMM) ea_nx = pc_in;
                end
            end
            S_OPLO: begin
                if (state_nx == S_OPHI) addr_nx = pc_in + ADDR_W'(1);
                else                    addr_nx = {ZP_HI, d_in};
                if (state_nx == S_DONE) ea_nx = {ZP_HI, d_in};
            end
            S_ZPIDX: begin
                // zero-page index wraps within the page: no carry used
                addr_nx = {ZP_HI, add_sum};
                ea_nx   = {ZP_HI, add_sum};
            end
            S_PTRLO: addr_nx = {ZP_HI, add_sum};
            S_OPHI, S_PTRHI: begin
                // With FIX this is the uncorrected dummy address; without
                // FIX it is already the final effective address.
                ea_nx   = indexed ? {d_hi, add_sum} : {d_hi, lo_q};
                addr_nx = ea_nx;
            end
            S_FIX: begin
                ea_nx   = {hi_q + HI_W'(page_cross), lo_q};
                addr_nx = ea_nx;
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            ea         <= '0;
            page_cross <= 1'b0;
            mode_q     <= M_IMM;
            store_q    <= 1'b0;
            idx_q      <= '0;
            lo_q       <= '0;
            ptr_q      <= '0;
            hi_q       <= '0;
        end else if (ready) begin
            addr <= addr_nx;
            ea   <= ea_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q     <= mode_in;
                        store_q    <= is_store;
                        idx_q      <= ((mode_in == M_ABSY) || (mode_in == M_INDY)) ? y_in : x_in;
                        page_cross <= 1'b0;
                    end
                end
                S_OPLO: begin
                    lo_q  <= d_in;
                    ptr_q <= d_in;
                end
                S_ZPIDX: ptr_q <= add_sum;
                S_PTRLO: lo_q  <= d_in;
                S_OPHI, S_PTRHI: begin
                    if (indexed) begin
                        hi_q       <= d_hi;
                        lo_q       <= add_sum;
                        page_cross <= add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/addr_mode_seq.md
ADDR_MODE_SEQ -- requirements
Module: addr_mode_seq

Interface
REQ-001 Parameter ADDR_W, default 16, address bus width; legal range 9..16; high byte is ADDR_W-8 bits.
REQ-002 Parameter ZP_BASE, default 0, upper address bits for zero-page and pointer accesses.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 ready  in  1  bus ready; low freezes all state and outputs.
REQ-006 start  in  1  begin address sequence; honoured only in IDLE with ready=1.
REQ-007 mode  in  3  addressing mode, sampled on start.
REQ-008 is_store  in  1  access is a write, sampled on start.
REQ-009 x_in, y_in  in  8 each  index registers, sampled on start.
REQ-010 pc_in  in  ADDR_W  current PC, address of the next operand byte.
REQ-011 d_in  in  8  read data, valid in the same cycle as addr.
REQ-012 addr  out  ADDR_W  bus address, registered.
REQ-013 pc_inc  out  1  operand byte consumed this cycle; caller increments PC.
REQ-014 busy  out  1  sequence in progress.
REQ-015 done  out  1  one-cycle pulse; ea valid.
REQ-016 ea  out  ADDR_W  effective address.
REQ-017 page_cross  out  1  indexed add carried into high byte; valid with done.

Function
REQ-018 Modes: 0 IMM, 1 ZP, 2 ZPX, 3 ABS, 4 ABSX, 5 ABSY, 6 INDX, 7 INDY.
REQ-019 States: IDLE, OPLO, OPHI, ZPIDX, PTRLO, PTRHI, FIX, DONE; every transition requires ready=1.
REQ-020 Latency from accepted start to done, with ready high: IMM 1, ZP 2, ZPX 3, ABS 3, ABSX/ABSY 3 (+1 on FIX), INDX 5, INDY 4 (+1 on FIX).
REQ-021 IMM: ea=pc_in, pc_inc=1 in the start cycle; next state DONE.
REQ-022 OPLO/OPHI: addr=pc_in, pc_inc=1, d_in captured as operand low/high byte.
REQ-023 ZPX: ZPIDX performs a dummy read at {ZP_BASE, base}; ea={ZP_BASE,(base+X) mod 256}, no carry propagates.
REQ-024 INDX: dummy read at base; pointer p=(base+X) mod 256; PTRLO reads p, PTRHI reads (p+1) mod 256.
REQ-025 INDY: PTRLO reads p, PTRHI reads (p+1) mod 256; ea = pointer + Y.
REQ-026 ABSX/ABSY/INDY: low sum = lo+idx; carry sets page_cross; FIX drives dummy address {hi, lo+idx mod 256}; then ea high = hi+1 mod 2^(ADDR_W-8).
REQ-027 FIX taken when carry=1 or is_store=1; otherwise skipped (see REQ-033).
REQ-028 DONE: done=1, busy=0 next cycle, return to IDLE; start in DONE is ignored.
REQ-029 busy=1 from the cycle after an accepted start through DONE inclusive; start while busy is ignored.
REQ-030 ready=0 in any state: state, addr, ea are held; pc_inc=0 and done=0 are forced.
REQ-031 ea high bits above ADDR_W are discarded; operand high byte is truncated to ADDR_W-8 bits.

Reset
REQ-032 reset_n low at any time, including mid-sequence: state=IDLE, addr=0, ea=0, pc_inc=0, busy=0, done=0, page_cross=0; no done is issued for the aborted sequence.

Configuration
REQ-033 Macro PAGE_PENALTY_EN: defined, FIX is conditional per REQ-027; undefined, FIX is always taken for ABSX/ABSY/INDY, giving fixed latencies 4/4/5, with page_cross still reported.

Structure
REQ-034 Package cpu_pkg holds the mode enum, the state enum, and the mode encodings; cpu and addr_mode_seq both import it.
REQ-035 One sub-module, ea_add8 (8-bit add with carry-out), is instantiated for index add and pointer increment.

Verification
REQ-036 ABS: mode=3, d_in bytes 0x34,0x12 -> done on cycle 3, ea=0x1234, two pc_inc pulses.
REQ-037 ABSX: X=0xFF, operand 0x12F0, load -> FIX dummy at 0x12EF, ea=0x13EF, page_cross=1, latency 4; same with operand 0x1200 -> ea=0x12FF, latency 3 (PAGE_PENALTY_EN defined).
REQ-038 ZPX: base 0xF0, X=0x20 -> ea=0x0010 (wrap), no page_cross.
REQ-039 INDY: p=0xFF, mem[0xFF]=0x80, mem[0x00]=0x20, Y=0x90 -> PTRHI reads 0x0000, ea=0x2110, page_cross=1, latency 5.
REQ-040 INDX mid-sequence reset_n pulse at PTRLO -> all outputs 0 immediately, no done; next start runs normally.
REQ-041 ABS with ready low for 3 cycles during OPHI -> addr held, no pc_inc, done delayed exactly 3 cycles, ea unchanged.
